// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Pipeline stage register with a valid/ready handshake. It has an optional
// one-entry skid buffer, synchronous flush and bubble insertion, and a
// saturating stall-cycle counter. Use it between adjacent pipeline stages,
// with the stage payload packed into one vector.
//
// Parameters:
//   DATA_W  payload width (1..256)
//   BUBBLE  payload presented/stored while no valid entry is held (NOP)
//   SKID_EN 1 = main + skid entry, registered in-ready
//           0 = single register, combinational in-ready
//   CNT_W   width of the stall counter
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_flush      synchronous kill of all held entries
//   i_cnt_clr    synchronous clear of the stall counter
//   i_in_valid   upstream payload valid
//   o_in_ready   stage accepts the upstream payload this cycle
//   i_in_data    upstream payload
//   o_out_valid  stage presents a valid payload
//   i_out_ready  downstream accepts this cycle
//   o_out_data   presented payload (BUBBLE when not valid)
//   o_occ        number of held entries (0..2)
//   o_stall_cnt  cycles a valid entry was held back by downstream
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int unsigned       DATA_W  = 32,
    parameter logic [DATA_W-1:0] BUBBLE  = {DATA_W{1'b0}},
    parameter int unsigned       SKID_EN = 1,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_cnt_clr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occ,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    localparam bit              LP_SKID    = (SKID_EN != 0);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

    // Storage: main entry is always the one presented downstream; the skid
    // entry only ever holds the payload accepted behind it.
    logic              r_m_vld;
    logic [DATA_W-1:0] r_m_dat;
    logic              r_s_vld;
    logic [DATA_W-1:0] r_s_dat;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_m_vld_nxt;
    logic [DATA_W-1:0] w_m_dat_nxt;
    logic              w_s_vld_nxt;
    logic [DATA_W-1:0] w_s_dat_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Handshake: in skid mode in-ready depends only on state and flush, so
    // downstream ready never propagates combinationally upstream.
    always_comb begin
        w_in_ready = 1'b0;
        if (LP_SKID) begin
            w_in_ready = ~r_s_vld & ~i_flush;
        end else begin
            w_in_ready = (~r_m_vld | i_out_ready) & ~i_flush;
        end
        w_out_valid = r_m_vld & ~i_flush;
        w_in_fire   = i_in_valid & w_in_ready;
        w_out_fire  = w_out_valid & i_out_ready;
    end

    // Next-state for the main and skid entries.
    always_comb begin
        w_m_vld_nxt = r_m_vld;
        w_m_dat_nxt = r_m_dat;
        w_s_vld_nxt = r_s_vld;
        w_s_dat_nxt = r_s_dat;
        if (i_flush) begin
            w_m_vld_nxt = 1'b0;
            w_m_dat_nxt = BUBBLE;
            w_s_vld_nxt = 1'b0;
            w_s_dat_nxt = BUBBLE;
        end else if (!r_m_vld) begin
            // Empty stage: a new payload goes straight into main.
            if (w_in_fire) begin
                w_m_vld_nxt = 1'b1;
                w_m_dat_nxt = i_in_data;
            end else begin
                w_m_dat_nxt = BUBBLE;
            end
        end else if (w_out_fire) begin
            if (r_s_vld) begin
                // Skid drains into main; in-ready was low, so no new payload.
                w_m_vld_nxt = 1'b1;
                w_m_dat_nxt = r_s_dat;
                w_s_vld_nxt = 1'b0;
                w_s_dat_nxt = BUBBLE;
            end else if (w_in_fire) begin
                w_m_vld_nxt = 1'b1;
                w_m_dat_nxt = i_in_data;
            end else begin
                w_m_vld_nxt = 1'b0;
                w_m_dat_nxt = BUBBLE;
            end
        end else if (w_in_fire && LP_SKID) begin
            // Main is stalled: the newly accepted payload waits in skid.
            w_s_vld_nxt = 1'b1;
            w_s_dat_nxt = i_in_data;
        end else begin
            w_m_vld_nxt = r_m_vld;
        end
    end

    // Stall counter next value: clear wins over increment; saturates.
    always_comb begin
        w_cnt_nxt = r_stall_cnt;
        if (i_cnt_clr) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (r_m_vld && !i_out_ready && !i_flush && (r_stall_cnt != LP_CNT_MAX)) begin
            w_cnt_nxt = r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_stall_cnt;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m_vld     <= 1'b0;
            r_m_dat     <= BUBBLE;
            r_s_vld     <= 1'b0;
            r_s_dat     <= BUBBLE;
            r_stall_cnt <= {CNT_W{1'b0}};
        end else begin
            r_m_vld     <= w_m_vld_nxt;
            r_m_dat     <= w_m_dat_nxt;
            r_s_vld     <= w_s_vld_nxt;
            r_s_dat     <= w_s_dat_nxt;
            r_stall_cnt <= w_cnt_nxt;
        end
    end

    // Output drive.
    always_comb begin
        o_in_ready  = w_in_ready;
        o_out_valid = w_out_valid;
        o_out_data  = r_m_vld ? r_m_dat : BUBBLE;
        o_occ       = {1'b0, r_m_vld} + {1'b0, r_s_vld};
        o_stall_cnt = r_stall_cnt;
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Drives a skid-mode instance (index 0, BUBBLE=0) and a single-register
// instance (index 1, non-zero BUBBLE) side by side. Both have CNT_W=4 and
// the same control inputs. Each instance has its own upstream source pointer
// and its own reference model. The model is a FIFO of capacity 2 or 1,
// which makes the ordering and latency rules easy to check.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        clr;
    logic        oready;
    logic        iv [2];
    logic [31:0] id [2];
    logic        ir [2];
    logic        ov [2];
    logic [31:0] od [2];
    logic [1:0]  oc [2];
    logic [3:0]  sc [2];

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // upstream source: one shared payload list, per-instance progress
    logic [31:0] src [512];
    int          nsrc;
    int          sp [2];
    bit          feed_en;

    // reference model
    int          msz  [2];
    logic [31:0] mq   [2][2];
    logic [3:0]  mcnt [2];
    logic [31:0] oga[$];
    logic [31:0] ogb[$];
    logic [31:0] exp_q[$];

    pipe_skid_stage #(.DATA_W(32), .BUBBLE(32'h0000_0000), .SKID_EN(1), .CNT_W(4)) u_a (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_cnt_clr(clr),
        .i_in_valid(iv[0]), .o_in_ready(ir[0]), .i_in_data(id[0]),
        .o_out_valid(ov[0]), .i_out_ready(oready), .o_out_data(od[0]),
        .o_occ(oc[0]), .o_stall_cnt(sc[0])
    );

    pipe_skid_stage #(.DATA_W(32), .BUBBLE(32'hA5A5_0F0F), .SKID_EN(0), .CNT_W(4)) u_b (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_cnt_clr(clr),
        .i_in_valid(iv[1]), .o_in_ready(ir[1]), .i_in_data(id[1]),
        .o_out_valid(ov[1]), .i_out_ready(oready), .o_out_data(od[1]),
        .o_occ(oc[1]), .o_stall_cnt(sc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bub(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input logic [31:0] got[$], input logic [31:0] want[$]);
        chk({tag, "_len"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s_%0d", tag, i), got[i], want[i]);
        end
    endtask

    task automatic load_src(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) src[i] = base + i;
        nsrc = n;
        sp[0] = 0;
        sp[1] = 0;
        oga.delete();
        ogb.delete();
    endtask

    // Skid-implies-main invariant on both instances, every cycle.
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            assert (!(u_a.r_s_vld && !u_a.r_m_vld) && !(u_b.r_s_vld && !u_b.r_m_vld)) else begin
                errors++;
                $error("FAIL inv_skid_implies_main observed=%b%b expected=no skid without main",
                       u_a.r_s_vld, u_a.r_m_vld);
            end
        end
    end

    // One clock cycle: drive upstream, check outputs against the model,
    // advance the model over the edge.
    task automatic tick();
        logic       e_ir;
        logic       e_ov;
        logic       fin;
        logic       fout;
        logic [31:0] e_od;
        for (int d = 0; d < 2; d++) begin
            iv[d] = feed_en && (sp[d] < nsrc);
            id[d] = (sp[d] < nsrc) ? src[sp[d]] : 32'h0000_0000;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            e_ov = (msz[d] > 0) && !flush;
            if (flush)       e_ir = 1'b0;
            else if (d == 0) e_ir = (msz[d] < 2);
            else             e_ir = (msz[d] == 0) || oready;
            e_od = (msz[d] > 0) ? mq[d][0] : bub(d);
            chk($sformatf("in_ready%0d", d),  ir[d], e_ir);
            chk($sformatf("out_valid%0d", d), ov[d], e_ov);
            chk($sformatf("out_data%0d", d),  od[d], e_od);
            chk($sformatf("occ%0d", d),       oc[d], msz[d]);
            chk($sformatf("stall_cnt%0d", d), sc[d], mcnt[d]);
            fin  = iv[d] && e_ir;
            fout = e_ov && oready;
            if (rst) begin
                msz[d]  = 0;
                mcnt[d] = 4'd0;
            end else begin
                if (clr) mcnt[d] = 4'd0;
                else if (msz[d] > 0 && !oready && !flush && mcnt[d] != 4'hF) mcnt[d] = mcnt[d] + 4'd1;
                if (flush) begin
                    msz[d] = 0;
                end else begin
                    if (fout) begin
                        if (d == 0) oga.push_back(mq[d][0]);
                        else        ogb.push_back(mq[d][0]);
                        mq[d][0] = mq[d][1];
                        msz[d]--;
                    end
                    if (fin) begin
                        mq[d][msz[d]] = id[d];
                        msz[d]++;
                    end
                end
            end
            if (fin) sp[d]++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset / bubble ----
        rst = 1'b1; flush = 1'b0; clr = 1'b0; oready = 1'b0; feed_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            msz[d] = 0; mcnt[d] = 4'd0; mq[d][0] = 32'h0; mq[d][1] = 32'h0;
            iv[d] = 1'b1; id[d] = 32'hDEAD_BEEF;
        end
        src[0] = 32'hDEAD_BEEF; nsrc = 1; sp[0] = 0; sp[1] = 0;
        @(posedge clk);
        #1;
        armed = 1'b1;
        src[0] = 32'hDEAD_BEEF; sp[0] = 0; sp[1] = 0;
        tick();
        tick();
        chk("rst_out_valid", ov[0], 1'b0);
        chk("rst_out_data", od[0], 32'h0000_0000);
        chk("rst_occ", oc[0], 2'd0);
        rst = 1'b0; feed_en = 1'b0;
        tick();
        chk("post_rst_in_ready_a", ir[0], 1'b1);
        chk("post_rst_in_ready_b", ir[1], 1'b1);

        // ---- streaming 1..8 ----
        load_src(32'd1, 8);
        oready = 1'b1; feed_en = 1'b1;
        repeat (10) tick();
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        chk_log("stream_a", oga, exp_q);
        chk_log("stream_b", ogb, exp_q);
        chk("stream_cnt_a", sc[0], 4'd0);

        // ---- skid absorb / single-register ----
        load_src(32'd10, 3);
        tick();                 // 10 accepted
        oready = 1'b0;
        tick();                 // 10 presented, downstream stalls, 11 into skid
        chk("absorb_occ_a", oc[0], 2'd2);
        chk("absorb_in_ready_a", ir[0], 1'b0);
        chk("absorb_in_ready_b", ir[1], 1'b0);
        chk("absorb_occ_b", oc[1], 2'd1);
        oready = 1'b1;
        #1;
        chk("follow_in_ready_b", ir[1], 1'b1);
        chk("absorb_hold_a", ir[0], 1'b0);
        repeat (6) tick();
        feed_en = 1'b0;
        exp_q = '{32'd10, 32'd11, 32'd12};
        chk_log("absorb_a", oga, exp_q);
        chk_log("absorb_b", ogb, exp_q);
        chk("absorb_cnt_a", sc[0], 4'd1);
        chk("absorb_cnt_b", sc[1], 4'd1);

        // ---- flush ----
        load_src(32'd20, 3);
        oready = 1'b0; feed_en = 1'b1;
        tick();
        tick();
        chk("pre_flush_occ_a", oc[0], 2'd2);
        flush = 1'b1; oready = 1'b1;
        #1;
        chk("flush_out_valid_a", ov[0], 1'b0);
        chk("flush_in_ready_a", ir[0], 1'b0);
        tick();
        flush = 1'b0;
        chk("post_flush_occ_a", oc[0], 2'd0);
        chk("post_flush_data_a", od[0], 32'h0000_0000);
        chk("post_flush_data_b", od[1], 32'hA5A5_0F0F);
        repeat (5) tick();
        feed_en = 1'b0;
        exp_q = '{32'd22};
        chk_log("flush_a", oga, exp_q);
        exp_q = '{32'd21, 32'd22};
        chk_log("flush_b", ogb, exp_q);

        // ---- stall counter saturation and clear ----
        clr = 1'b1;
        tick();
        clr = 1'b0;
        load_src(32'd30, 1);
        oready = 1'b0; feed_en = 1'b1;
        repeat (22) tick();
        chk("sat_a", sc[0], 4'd15);
        chk("sat_b", sc[1], 4'd15);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_zero_a", sc[0], 4'd0);
        tick();
        chk("clr_then_one_a", sc[0], 4'd1);
        oready = 1'b1; feed_en = 1'b0;
        repeat (3) tick();

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 500; i++) src[i] = $urandom;
        nsrc = 500; sp[0] = 0; sp[1] = 0;
        for (int i = 0; i < 400; i++) begin
            feed_en = ($urandom_range(0, 3) != 0);
            oready  = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            clr     = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; clr = 1'b0; oready = 1'b1; feed_en = 1'b0;
        repeat (4) tick();
        armed = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with valid/ready handshake, an optional one-entry skid buffer, synchronous flush and bubble insertion, and a saturating stall-cycle counter. It is the general replacement for the fixed per-stage registers between adjacent pipeline stages (IF/ID/EX/DF/MEM/WB). A stage boundary instantiates it with its payload packed into one vector, such as ALU op, GPR write enable/address/data, SRAM byte enables or load data. Downstream backpressure then propagates without a global stall vector.

## Interface
- DATA_W, 32: payload width in bits, 1..256.
- BUBBLE, {DATA_W{1'b0}}: payload value presented and stored when the stage holds no valid entry (the NOP encoding).
- SKID_EN, 1: 1 = two-entry skid mode (registered IN_READY); 0 = single-register mode (IN_READY combinational).
- CNT_W, 16: width of STALL_CNT.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- FLUSH  in  1  synchronous kill of all held entries.
- CNT_CLR  in  1  synchronous clear of STALL_CNT.
- IN_VALID  in  1  upstream has a payload.
- IN_READY  out  1  stage accepts the payload this cycle.
- IN_DATA  in  DATA_W  upstream payload.
- OUT_VALID  out  1  stage presents a valid payload.
- OUT_READY  in  1  downstream accepts this cycle.
- OUT_DATA  out  DATA_W  presented payload; BUBBLE when OUT_VALID=0.
- OCC  out  2  number of held entries (0..2; max 1 when SKID_EN=0).
- STALL_CNT  out  CNT_W  cycles a valid entry was held back by downstream.

## Operation
- Storage: main entry (m_vld, m_dat) and skid entry (s_vld, s_dat). The skid entry is absent when SKID_EN=0.
- in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- OUT_VALID = m_vld & ~FLUSH; OUT_DATA = m_vld ? m_dat : BUBBLE.
- SKID_EN=1:
  - IN_READY = ~s_vld & ~FLUSH; depends only on state and FLUSH, never on OUT_READY.
  - m empty: in_fire loads m.
  - m full, out_fire, s full: m <= s, s cleared; in_fire is impossible.
  - m full, out_fire, s empty: m <= IN_DATA if in_fire, else m_vld <= 0 and m_dat <= BUBBLE.
  - m full, no out_fire, in_fire: s <= IN_DATA.
  - m full, no out_fire, no in_fire: hold.
- SKID_EN=0:
  - IN_READY = (~m_vld | OUT_READY) & ~FLUSH.
  - in_fire loads m.
  - out_fire without in_fire empties m to BUBBLE.
  - Otherwise hold.
- Ordering: payloads leave strictly in acceptance order. No payload is duplicated or dropped except by FLUSH.
- FLUSH (priority below RST, above everything else):
  - Next edge clears m_vld and s_vld and loads BUBBLE into both data registers.
  - IN_DATA in the flush cycle is not accepted (IN_READY=0).
  - No output transfer occurs in the flush cycle (OUT_VALID=0).
- OCC = m_vld + s_vld (registered state).
- STALL_CNT:
  - Increments when m_vld & ~OUT_READY & ~FLUSH.
  - Saturates at all-ones.
  - CNT_CLR has priority over increment; clearing and incrementing in the same cycle gives 0.
- Invariant: s_vld=1 implies m_vld=1. An assertion is required in the bench.

## Timing
- Reset values (edge with RST=1): m_vld=s_vld=0, m_dat=s_dat=BUBBLE, STALL_CNT=0.
- After reset: OUT_VALID=0, OUT_DATA=BUBBLE, OCC=0, IN_READY=1 (if FLUSH=0).
- RST mid-transfer discards all held entries with no partial state. FLUSH and CNT_CLR are ignored while RST=1.
- Latency: a payload accepted at edge k is on OUT_DATA with OUT_VALID=1 in cycle k+1; it is never combinationally forwarded.
- Throughput: one transfer per cycle when OUT_READY=1 continuously, in both modes.
- SKID_EN=1:
  - The first OUT_READY drop is absorbed by s; IN_READY falls one cycle later.
  - IN_READY rises the cycle after the edge on which s drains into m.
- Simultaneous in_fire and out_fire with OCC=1: occupancy stays 1 and m takes the new payload.
- FLUSH together with OUT_READY=1: nothing transfers; the stage is empty next cycle.

## Test plan
- Reset/bubble: DATA_W=32, BUBBLE=32'h0000_0000. Assert RST for 2 cycles with IN_VALID=1, IN_DATA=32'hDEAD_BEEF. Required: OUT_VALID=0, OUT_DATA=0, OCC=0, STALL_CNT=0 throughout; IN_READY=1 after RST deasserts.
- Streaming: feed 1,2,3,...,8 back-to-back with OUT_READY=1. Required: outputs 1..8 in cycles k+1..k+8, OCC=1 steady, STALL_CNT=0.
- Skid absorb (SKID_EN=1):
  - Feed 10,11,12 and drop OUT_READY in the cycle that 10 is presented.
  - Required: 11 lands in s, OCC=2, IN_READY=0, 12 is held upstream.
  - Raise OUT_READY: output sequence 10,11,12 with no loss; STALL_CNT=1.
- Single-register mode (SKID_EN=0): the same stimulus. Required: IN_READY follows OUT_READY in the same cycle, OCC never exceeds 1, output 10,11,12.
- Flush: with OCC=2 (entries 20,21) and IN_VALID=1, IN_DATA=22, assert FLUSH for 1 cycle. Required:
  - In the flush cycle: OUT_VALID=0, IN_READY=0.
  - Next cycle: OCC=0, OUT_DATA=BUBBLE.
  - 22 is accepted only after FLUSH drops and appears one cycle later.
- Counter: CNT_W=4, hold a valid entry with OUT_READY=0 for 20 cycles. Required: STALL_CNT saturates at 15. CNT_CLR for one cycle during a stall yields 0, then 1 on the following cycle.
